// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory loader/responder.
// Holds the fetch NOP encoding and the loader state type.
package riscv_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } imem_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// A short final word is zero-padded in its upper lanes.
module imem_word_packer
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  ld_byte,
    input  logic        last,
    output logic        wr_en,
    output logic [31:0] wr_data
);

    logic [1:0]  lane;
    logic [23:0] acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane <= 2'd0;
            acc  <= '0;
        end else if (clear) begin
            lane <= 2'd0;
            acc  <= '0;
        end else if (accept) begin
            if (last || lane == 2'd3) begin
                lane <= 2'd0;
                acc  <= '0;
            end else begin
                lane <= lane + 2'd1;
                unique case (lane)
                    2'd0:    acc[7:0]   <= ld_byte;
                    2'd1:    acc[15:8]  <= ld_byte;
                    default: acc[23:16] <= ld_byte;
                endcase
            end
        end
    end

    // The incoming byte lands directly in the written word
    always_comb begin
        wr_data = '0;
        unique case (lane)
            2'd0: wr_data = {24'h0, ld_byte};
            2'd1: wr_data = {16'h0, ld_byte, acc[7:0]};
            2'd2: wr_data = {8'h0, ld_byte, acc[15:0]};
            2'd3: wr_data = {ld_byte, acc[23:0]};
        endcase
    end

    assign wr_en = accept && (last || lane == 2'd3);

endmodule

// File: rtl/imem_loader_responder.sv
// Instruction RAM filled by a byte loader, answering core fetches.
// Optional IMEM_ALIGN_CHECK_EN adds a sticky misaligned-PC flag.
module imem_loader_responder
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_start,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [7:0]    ld_byte,
    input  logic          ld_last,
    input  logic [31:0]   PC_o,
    output logic [31:0]   ins_i,
    output logic          cpu_hold,
    output logic [AW:0]   ld_words,
    output logic          ld_err
`ifdef IMEM_ALIGN_CHECK_EN
    ,
    output logic          pc_misalign
`endif
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    imem_state_t state, state_nx;
    logic [AW-1:0] wptr;
    logic [31:0]   mem [DEPTH];
    logic          accept;
    logic          wr_en;
    logic [31:0]   wr_data;
    logic          full;
    logic          pc_ok;

    // ld_start wins over a byte offered in the same cycle
    assign ld_ready = (state == LOAD);
    assign accept   = ld_valid && ld_ready && !ld_start;
    assign cpu_hold = (state != RUN);
    assign full     = (ld_words == FULL);

    imem_word_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .clear   (ld_start),
        .accept  (accept),
        .ld_byte (ld_byte),
        .last    (ld_last),
        .wr_en   (wr_en),
        .wr_data (wr_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (ld_start) state_nx = LOAD;
            LOAD: begin
                if (ld_start)              state_nx = LOAD;
                else if (accept && ld_last) state_nx = RUN;
            end
            RUN:  if (ld_start) state_nx = LOAD;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            ld_words <= '0;
            ld_err   <= 1'b0;
        end else if (ld_start) begin
            wptr     <= '0;
            ld_words <= '0;
            ld_err   <= 1'b0;
        end else if (wr_en) begin
            if (full) begin
                ld_err <= 1'b1;
            end else begin
                wptr     <= wptr + 1'b1;
                ld_words <= ld_words + 1'b1;
            end
        end
    end

    // RAM contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en && !ld_start && !full)
            mem[wptr] <= wr_data;
    end

`ifdef IMEM_ALIGN_CHECK_EN
    assign pc_ok = (PC_o[1:0] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc_misalign <= 1'b0;
        else if (ld_start)
            pc_misalign <= 1'b0;
        else if (state == RUN && !pc_ok)
            pc_misalign <= 1'b1;
    end
`else
    logic unused_pc;
    assign pc_ok     = 1'b1;
    assign unused_pc = ^PC_o[1:0];
`endif

    always_comb begin
        ins_i = RV_NOP;
        if (state == RUN && PC_o[31:AW+2] == '0 && pc_ok)
            ins_i = mem[PC_o[AW+1:2]];
    end

endmodule

// File: tb/tb_imem_loader_responder.sv
// Directed bench for imem_loader_responder with a 4-word RAM.
// Covers load, padding, overflow, reload, start/byte collision, reset.
module tb_imem_loader_responder;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_start;
    logic          ld_valid;
    logic          ld_ready;
    logic [7:0]    ld_byte;
    logic          ld_last;
    logic [31:0]   PC_o;
    logic [31:0]   ins_i;
    logic          cpu_hold;
    logic [AW:0]   ld_words;
    logic          ld_err;
`ifdef IMEM_ALIGN_CHECK_EN
    logic          pc_misalign;
`endif

    int total = 0;
    int bad   = 0;
    int stalls = 0;

    imem_loader_responder #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_byte  (ld_byte),
        .ld_last  (ld_last),
        .PC_o     (PC_o),
        .ins_i    (ins_i),
        .cpu_hold (cpu_hold),
        .ld_words (ld_words),
        .ld_err   (ld_err)
`ifdef IMEM_ALIGN_CHECK_EN
        ,
        .pc_misalign (pc_misalign)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        if (!ld_ready) stalls++;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic start();
        @(negedge clk);
        ld_start = 1'b1;
        @(posedge clk);
        #1;
        ld_start = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] pc,
                         input logic [31:0] exp);
        PC_o = pc;
        #1;
        check(tag, ins_i, exp);
    endtask

    initial begin
        rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0;
        ld_byte = 8'h0; ld_last = 1'b0; PC_o = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold",  {31'b0, cpu_hold}, 32'd1);
        check("rst_ready", {31'b0, ld_ready}, 32'd0);
        check("rst_ins",   ins_i, 32'h0000_0013);
        check("rst_words", {29'b0, ld_words}, 32'd0);
        check("rst_err",   {31'b0, ld_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // two-word program
        start();
        check("ld_ready",  {31'b0, ld_ready}, 32'd1);
        check("ld_hold",   {31'b0, cpu_hold}, 32'd1);
        send(8'h13, 0); send(8'h05, 0); send(8'hA0, 0); send(8'h00, 0);
        send(8'h93, 0); send(8'h05, 0); send(8'hB0, 0); send(8'h00, 1);
        check("p1_hold",  {31'b0, cpu_hold}, 32'd0);
        check("p1_ready", {31'b0, ld_ready}, 32'd0);
        check("p1_words", {29'b0, ld_words}, 32'd2);
        fetch("p1_w0", 32'h0, 32'h00A0_0513);
        fetch("p1_w1", 32'h4, 32'h00B0_0593);
        fetch("p1_oor", 32'h10, 32'h0000_0013);
`ifndef IMEM_ALIGN_CHECK_EN
        fetch("p1_lowbits", 32'h6, 32'h00B0_0593);
`endif

        // reload from RUN with a padded final word
        start();
        check("re_hold",  {31'b0, cpu_hold}, 32'd1);
        fetch("re_nop", 32'h0, 32'h0000_0013);
        check("re_words", {29'b0, ld_words}, 32'd0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        send(8'hEF, 0); send(8'hBE, 1);
        check("pad_words", {29'b0, ld_words}, 32'd2);
        fetch("pad_w0", 32'h0, 32'h4433_2211);
        fetch("pad_w1", 32'h4, 32'h0000_BEEF);

        // overflow: 20 bytes into a 4-word RAM
        start();
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            send(8'(i + 1), i == 19);
            if (i == 15) begin
                check("ovf_full_err", {31'b0, ld_err}, 32'd0);
                check("ovf_full_words", {29'b0, ld_words}, 32'd4);
            end
        end
        check("ovf_err",    {31'b0, ld_err}, 32'd1);
        check("ovf_words",  {29'b0, ld_words}, 32'd4);
        check("ovf_stalls", stalls, 32'd0);
        fetch("ovf_w0", 32'h0, 32'h0403_0201);
        fetch("ovf_w3", 32'hC, 32'h100F_0E0D);

        // reload a single word; ld_start clears the error
        start();
        check("rl_err",  {31'b0, ld_err}, 32'd0);
        check("rl_hold", {31'b0, cpu_hold}, 32'd1);
        send(8'h78, 0); send(8'h56, 0); send(8'h34, 0); send(8'h12, 1);
        check("rl_words", {29'b0, ld_words}, 32'd1);
        fetch("rl_w0", 32'h0, 32'h1234_5678);
        fetch("rl_w1", 32'h4, 32'h0807_0605);

        // ld_start collides with an offered byte: byte is discarded
        start();
        @(negedge clk);
        ld_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'hAA;
        @(posedge clk);
        #1;
        ld_start = 1'b0; ld_valid = 1'b0;
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
        check("col_words", {29'b0, ld_words}, 32'd1);
        fetch("col_w0", 32'h0, 32'h0403_0201);

`ifdef IMEM_ALIGN_CHECK_EN
        fetch("mis_ins", 32'h6, 32'h0000_0013);
        @(posedge clk);
        #1;
        check("mis_set", {31'b0, pc_misalign}, 32'd1);
        PC_o = 32'h0;
        @(posedge clk);
        #1;
        check("mis_sticky", {31'b0, pc_misalign}, 32'd1);
`endif

        // asynchronous reset in the middle of a load
        start();
        send(8'h55, 0); send(8'h66, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("ar_hold",  {31'b0, cpu_hold}, 32'd1);
        check("ar_ready", {31'b0, ld_ready}, 32'd0);
        check("ar_words", {29'b0, ld_words}, 32'd0);
        fetch("ar_ins", 32'h0, 32'h0000_0013);
`ifdef IMEM_ALIGN_CHECK_EN
        check("ar_mis", {31'b0, pc_misalign}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
